serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock periods per serial bit; legal range is 1 to 1024.
REQ-002 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port CLR_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port D, input, DATA_W bits: parallel payload to transmit.
REQ-006 SHALL have port LOAD, input, 1 bit: request to transmit D.
REQ-007 SHALL have port READY, output, 1 bit: high when the block can accept LOAD.
REQ-008 SHALL have port TXD, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port BUSY, output, 1 bit: high while a frame is on the line; it is the inverse of READY.

Function
REQ-010 SHALL send each frame as: start bit (0), DATA_W payload bits LSB first, even-parity bit, stop bit (1). The frame is 11 bits at DATA_W=8.
REQ-011 SHALL hold every frame bit on TXD for exactly CLKS_PER_BIT clock periods.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY and STOP with these transitions:
- IDLE->START on accepted LOAD.
- START->DATA after one bit period.
- DATA->PARITY after DATA_W bit periods.
- PARITY->STOP after one bit period.
- STOP->IDLE after one bit period.
REQ-013 SHALL drive READY combinationally high only in IDLE.
REQ-014 SHALL accept LOAD only at a rising edge where LOAD=1 and READY=1; LOAD at any other time SHALL be ignored and SHALL NOT be queued.
REQ-015 SHALL latch D into an internal shift register on the accepting edge; later changes to D SHALL NOT affect the frame in flight.
REQ-016 SHALL drive TXD from a register. TXD SHALL go to 0 immediately after the accepting edge k, with zero added latency.
REQ-017 SHALL return to IDLE at edge k+(DATA_W+3)*CLKS_PER_BIT. The earliest next accept SHALL be edge k+(DATA_W+3)*CLKS_PER_BIT+1, with TXD=1 for at least one cycle between frames.
REQ-018 SHALL compute parity as the XOR of all DATA_W latched bits, so that payload plus parity has an even number of ones.
REQ-019 SHALL, when CLKS_PER_BIT=1, change the bit on every clock edge with no skipped or repeated bits.
REQ-020 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT), minimum 1 bit. It SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-021 SHALL use a payload bit index of width clog2(DATA_W). It SHALL clear on entry to DATA and SHALL NOT overflow past DATA_W-1.
REQ-022 SHALL hold TXD=1 in IDLE indefinitely while LOAD=0.

Reset
REQ-023 SHALL, on CLR_N=0, immediately and without waiting for CLK, force:
- state IDLE;
- TXD=1, READY=1, BUSY=0;
- both counters 0;
- shift register 0.
REQ-024 SHALL abort any frame in progress when reset is asserted mid-frame and SHALL NOT resume it after release.
REQ-025 SHALL ignore LOAD on the first rising edge after CLR_N deasserts only if CLR_N is still low at that edge; otherwise normal acceptance applies.

Structure
REQ-026 SHALL place the state enum type and the frame constants (START_BIT=0, STOP_BIT=1, OVERHEAD_BITS=3) in shared package serial_pkg, for reuse by a future receiver.
REQ-027 SHALL isolate the bit-period counter in sub-module bit_timer, which has ports CLK, CLR_N, EN and TICK and is parameterized by CLKS_PER_BIT.
REQ-028 SHALL contain no latches; all storage SHALL be edge-triggered on CLK with asynchronous CLR_N.

Verification
REQ-029 SHALL cover frame A5: N=4, D=8'hA5, LOAD pulsed one cycle in IDLE -> TXD sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 4 cycles, and READY high again after 44 cycles.
REQ-030 SHALL cover odd-weight parity: D=8'h07 -> parity bit 1; D=8'h00 -> parity bit 0 and payload all zeros.
REQ-031 SHALL cover ignored LOAD and D changes: LOAD=1 held for the whole frame, with D changed to 8'hFF mid-frame -> exactly one frame of the originally latched D. A second frame starts only after the 1-cycle idle gap, with D=8'hFF.
REQ-032 SHALL cover reset mid-frame: CLR_N pulled low during payload bit 3 -> TXD=1, READY=1 within the same cycle, with no CLK edge needed. After release, a LOAD of 8'h3C produces a clean full frame.
REQ-033 SHALL cover N=1 at maximum rate: D=8'h81 -> TXD 0,1,0,0,0,0,0,0,1,0,1 on 11 consecutive cycles, then READY high.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial framing definitions: transmitter state type and frame constants,
// kept here so a future receiver decodes the same frame layout.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   OVERHEAD_BITS = 3;

  // Counter width helper: clog2 of a count, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel-load side of the serial transmitter plus its serial line output.
// Handshake: a word D is taken on a rising edge where LOAD=1 and READY=1; LOAD at
// any other time is dropped, never queued. BUSY is always the inverse of READY.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] D;
  logic              LOAD;
  logic              READY;
  logic              TXD;
  logic              BUSY;

  modport master (
    output D,
    output LOAD,
    input  READY,
    input  TXD,
    input  BUSY
  );

  modport slave (
    input  D,
    input  LOAD,
    output READY,
    output TXD,
    output BUSY
  );
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period with TICK.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic EN,
  output logic TICK
);

  localparam int               CNT_W = min1_clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Held at zero while disabled so the first period after enable is full length.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      count <= '0;
    end else if (!EN || TICK) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign TICK = EN && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W payload bits LSB first, even parity, stop
// bit, each held CLKS_PER_BIT clocks; TXD is a register and idles high.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DATA_W-1:0] D,
  input  logic              LOAD,
  output logic              READY,
  output logic              TXD,
  output logic              BUSY,
  output tx_state_e         state
);

  localparam int               IDX_W    = min1_clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_rot;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic              timer_en;

  assign timer_en = (state != IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .EN   (timer_en),
    .TICK (tick)
  );

  // Rotating rather than shifting leaves the latched word intact after the last
  // payload bit, so parity is taken straight from the register.
  assign shreg_rot = DATA_W'({shreg[0], shreg} >> 1);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= IDLE;
      TXD   <= 1'b1;
      shreg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            state <= START;
            TXD   <= START_BIT;
            shreg <= D;
            idx   <= '0;
          end else begin
            TXD <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            TXD   <= shreg[0];
            shreg <= shreg_rot;
            idx   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == IDX_LAST) begin
              state <= PARITY;
              TXD   <= ^shreg;
            end else begin
              TXD   <= shreg[0];
              shreg <= shreg_rot;
              idx   <= idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            TXD   <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            TXD   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
        end
      endcase
    end
  end

  assign READY = (state == IDLE);
  assign BUSY  = ~READY;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit) checked cycle by
// cycle against a frame model built from the framing rules.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int N_SLOW = 4;
  localparam int N_FAST = 1;
  localparam int DW     = 8;

  // clock / reset
  logic CLK   = 1'b0;
  logic CLR_N = 1'b1;
  always #5 CLK = ~CLK;

  serial_tx_if #(.DATA_W(DW)) bus4 ();
  serial_tx_if #(.DATA_W(DW)) bus1 ();
  tx_state_e state4;
  tx_state_e state1;

  serial_tx #(.CLKS_PER_BIT(N_SLOW), .DATA_W(DW)) u_dut4 (
    .CLK(CLK), .CLR_N(CLR_N), .D(bus4.D), .LOAD(bus4.LOAD),
    .READY(bus4.READY), .TXD(bus4.TXD), .BUSY(bus4.BUSY), .state(state4)
  );

  serial_tx #(.CLKS_PER_BIT(N_FAST), .DATA_W(DW)) u_dut1 (
    .CLK(CLK), .CLR_N(CLR_N), .D(bus1.D), .LOAD(bus1.LOAD),
    .READY(bus1.READY), .TXD(bus1.TXD), .BUSY(bus1.BUSY), .state(state1)
  );

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  logic sel_fast = 1'b0;
  wire  obs_txd   = sel_fast ? bus1.TXD   : bus4.TXD;
  wire  obs_ready = sel_fast ? bus1.READY : bus4.READY;
  wire  obs_busy  = sel_fast ? bus1.BUSY  : bus4.BUSY;

  // reference model: one expected TXD value per clock for a whole frame
  function automatic void model_frame(input logic [DW-1:0] data, input int n);
    logic [0:0] bits[$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int b = 0; b < DW; b++) begin
      bits.push_back(data[b]);
      ones += int'(data[b]);
    end
    bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    foreach (bits[j]) repeat (n) exp_q.push_back(bits[j]);
  endfunction

  // driver: only the selected instance sees LOAD
  task automatic drive(input logic [DW-1:0] d, input logic ld);
    if (sel_fast) begin
      bus1.D = d; bus1.LOAD = ld; bus4.LOAD = 1'b0;
    end else begin
      bus4.D = d; bus4.LOAD = ld; bus1.LOAD = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 CLR_N = 1'b0;
    bus4.D = 8'h5A; bus4.LOAD = 1'b1;
    bus1.D = 8'h5A; bus1.LOAD = 1'b1;
    #1;
    checks++;
    if (bus4.TXD !== 1'b1 || bus4.READY !== 1'b1 || bus4.BUSY !== 1'b0 || state4 !== IDLE) begin
      errors++;
      $display("FAIL reset_async_n4 txd=%b ready=%b busy=%b state=%0d want 1 1 0 0", bus4.TXD, bus4.READY, bus4.BUSY, state4);
    end
    checks++;
    if (bus1.TXD !== 1'b1 || bus1.READY !== 1'b1 || bus1.BUSY !== 1'b0 || state1 !== IDLE) begin
      errors++;
      $display("FAIL reset_async_n1 txd=%b ready=%b busy=%b state=%0d want 1 1 0 0", bus1.TXD, bus1.READY, bus1.BUSY, state1);
    end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (state4 !== IDLE || bus4.TXD !== 1'b1 || state1 !== IDLE || bus1.TXD !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_ignored state4=%0d txd4=%b state1=%0d txd1=%b want idle, txd 1", state4, bus4.TXD, state1, bus1.TXD);
    end
    bus4.LOAD = 1'b0; bus1.LOAD = 1'b0;
    CLR_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus4.READY !== 1'b1 || bus4.TXD !== 1'b1 || bus1.READY !== 1'b1 || bus1.TXD !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_hold ready4=%b txd4=%b ready1=%b txd1=%b want all 1", bus4.READY, bus4.TXD, bus1.READY, bus1.TXD);
    end
  endtask

  task automatic test_frame_a5();
    int n;
    logic [0:0] exp;
    sel_fast = 1'b0;
    @(negedge CLK);
    drive(8'hA5, 1'b1);
    model_frame(8'hA5, N_SLOW);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) drive(8'hA5, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp || obs_busy !== 1'b1 || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL a5_bit cycle=%0d txd=%b busy=%b ready=%b want txd=%b busy=1 ready=0", i, obs_txd, obs_busy, obs_ready, exp);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready_after ready=%b txd=%b want 1 1", obs_ready, obs_txd);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] pats[2];
    int n;
    logic [0:0] exp;
    pats[0] = 8'h07;
    pats[1] = 8'h00;
    sel_fast = 1'b0;
    foreach (pats[p]) begin
      @(negedge CLK);
      drive(pats[p], 1'b1);
      model_frame(pats[p], N_SLOW);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge CLK);
        if (i == 0) drive(pats[p], 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (obs_txd !== exp) begin
          errors++;
          $display("FAIL parity_frame d=%h cycle=%0d txd=%b want %b", pats[p], i, obs_txd, exp);
        end
      end
      @(negedge CLK);
      checks++;
      if (obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL parity_ready d=%h ready=%b want 1", pats[p], obs_ready);
      end
    end
  endtask

  task automatic test_hold_load();
    logic [DW-1:0] d0;
    int n;
    logic [0:0] exp;
    sel_fast = 1'b0;
    d0 = DW'($urandom_range(0, 8'hFE));
    @(negedge CLK);
    drive(d0, 1'b1);
    model_frame(d0, N_SLOW);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 20) drive(8'hFF, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp || obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_first d=%h cycle=%0d txd=%b busy=%b want txd=%b busy=1", d0, i, obs_txd, obs_busy, exp);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
      errors++;
      $display("FAIL hold_gap ready=%b txd=%b want 1 1", obs_ready, obs_txd);
    end
    model_frame(8'hFF, N_SLOW);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) drive(8'hFF, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp) begin
        errors++;
        $display("FAIL hold_second cycle=%0d txd=%b want %b", i, obs_txd, exp);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
      errors++;
      $display("FAIL hold_end ready=%b txd=%b want 1 1", obs_ready, obs_txd);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d0;
    int n;
    logic [0:0] exp;
    sel_fast = 1'b0;
    d0 = DW'($urandom);
    @(negedge CLK);
    drive(d0, 1'b1);
    model_frame(d0, N_SLOW);
    // payload bit 3 is frame bit 4; stop partway through it
    for (int i = 0; i <= 4 * N_SLOW + 1; i++) begin
      @(negedge CLK);
      if (i == 0) drive(d0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp) begin
        errors++;
        $display("FAIL rstmid_pre cycle=%0d txd=%b want %b", i, obs_txd, exp);
      end
    end
    exp_q.delete();
    CLR_N = 1'b0;
    #1;
    checks++;
    if (obs_txd !== 1'b1 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || state4 !== IDLE) begin
      errors++;
      $display("FAIL rstmid_async txd=%b ready=%b busy=%b state=%0d want 1 1 0 0", obs_txd, obs_ready, obs_busy, state4);
    end
    drive(8'h3C, 1'b1);
    @(negedge CLK);
    checks++;
    if (obs_txd !== 1'b1 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_held txd=%b ready=%b want 1 1", obs_txd, obs_ready);
    end
    CLR_N = 1'b1;
    model_frame(8'h3C, N_SLOW);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) drive(8'h3C, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp || obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_3c cycle=%0d txd=%b busy=%b want txd=%b busy=1", i, obs_txd, obs_busy, exp);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_end ready=%b txd=%b want 1 1", obs_ready, obs_txd);
    end
  endtask

  task automatic test_max_rate();
    int n;
    logic [0:0] exp;
    sel_fast = 1'b1;
    @(negedge CLK);
    drive(8'h81, 1'b1);
    model_frame(8'h81, N_FAST);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) drive(8'h81, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_txd !== exp || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL maxrate_bit cycle=%0d txd=%b ready=%b want txd=%b ready=0", i, obs_txd, obs_ready, exp);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
      errors++;
      $display("FAIL maxrate_ready ready=%b txd=%b want 1 1", obs_ready, obs_txd);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int n, p, gap;
    logic [0:0] exp;
    @(negedge CLK);
    for (int f = 0; f < 16; f++) begin
      sel_fast = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge CLK);
        checks++;
        if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
          errors++;
          $display("FAIL rand_idle frame=%0d ready=%b txd=%b want 1 1", f, obs_ready, obs_txd);
        end
      end
      drive(d, 1'b1);
      model_frame(d, sel_fast ? N_FAST : N_SLOW);
      n = exp_q.size();
      p = $urandom_range(1, n - 3);
      for (int i = 0; i < n; i++) begin
        @(negedge CLK);
        if (i == 0) drive(d, 1'b0);
        if (i == p) drive(DW'($urandom), 1'b1);
        if (i == p + 1) drive(d, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (obs_txd !== exp || obs_busy !== 1'b1) begin
          errors++;
          $display("FAIL rand_bit frame=%0d fast=%0d d=%h cycle=%0d txd=%b busy=%b want txd=%b busy=1", f, sel_fast, d, i, obs_txd, obs_busy, exp);
        end
      end
      @(negedge CLK);
      checks++;
      if (obs_ready !== 1'b1 || obs_txd !== 1'b1) begin
        errors++;
        $display("FAIL rand_end frame=%0d ready=%b txd=%b want 1 1", f, obs_ready, obs_txd);
      end
    end
    drive('0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.D = '0; bus4.LOAD = 1'b0;
    bus1.D = '0; bus1.LOAD = 1'b0;
    test_reset();
    test_frame_a5();
    test_parity();
    test_hold_load();
    test_reset_mid();
    test_max_rate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
